// File: rtl/pwm_wb_pkg.sv
// Shared constants and helpers for the PWM Wishbone register bank.
package pwm_wb_pkg;

  localparam int unsigned NCH = 8;

  // Byte offsets of the register map; bits [1:0] are ignored on decode.
  localparam logic [7:0] ADR_T_BASE = 8'h00;
  localparam logic [7:0] ADR_D_BASE = 8'h20;
  localparam logic [7:0] ADR_EN     = 8'h40;
  localparam logic [7:0] ADR_COMMIT = 8'h44;
  localparam logic [7:0] ADR_STATUS = 8'h48;
  localparam logic [7:0] ADR_ID     = 8'h4C;
  localparam logic [7:0] ADR_KILL   = 8'h50;

  // STATUS register layout.
  localparam int unsigned STATUS_PEND_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB  = 8;

  // Merge write data into an old word, one byte lane per select bit.
  function automatic logic [31:0] apply_sel(logic [31:0] old_val, logic [31:0] wdat,
                                            logic [3:0] sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_wb_if.sv
// Wishbone B4 classic bus bundle between a master and the PWM register bank.
interface pwm_wb_if;

  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/pwm_wb_chan.sv
// One PWM channel: staged and active period/high-time with byte-lane writes
// and a single-cycle commit copy from staged to active.
module pwm_wb_chan
  import pwm_wb_pkg::*;
#(
  parameter logic [31:0] ResetPeriod = 32'd1_000_000,
  parameter logic [31:0] ResetDuty   = 32'd75_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        t_we_i,
  input  logic        d_we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdat_i,
  input  logic        commit_i,
  output logic [31:0] t_stg_o,
  output logic [31:0] d_stg_o,
  output logic [31:0] t_o,
  output logic [31:0] d_o
);

  logic [31:0] t_stg_q, t_stg_d, d_stg_q, d_stg_d;
  logic [31:0] t_act_q, t_act_d, d_act_q, d_act_d;

  // Next-state: staged words take byte-lane writes, active words copy on commit.
  always_comb begin
    t_stg_d = t_stg_q;
    d_stg_d = d_stg_q;
    t_act_d = t_act_q;
    d_act_d = d_act_q;
    if (t_we_i) t_stg_d = apply_sel(t_stg_q, wdat_i, sel_i);
    if (d_we_i) d_stg_d = apply_sel(d_stg_q, wdat_i, sel_i);
    if (commit_i) begin
      t_act_d = t_stg_q;
      d_act_d = d_stg_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_stg_q <= ResetPeriod;
      d_stg_q <= ResetDuty;
      t_act_q <= ResetPeriod;
      d_act_q <= ResetDuty;
    end else begin
      t_stg_q <= t_stg_d;
      d_stg_q <= d_stg_d;
      t_act_q <= t_act_d;
      d_act_q <= d_act_d;
    end
  end

  assign t_stg_o = t_stg_q;
  assign d_stg_o = d_stg_q;
  assign t_o     = t_act_q;
  assign d_o     = d_act_q;

endmodule

// File: rtl/pwm_wb_regs.sv
// Wishbone register bank feeding the 8-channel PWM generator: staged values,
// atomic commit of all channels, and an emergency kill of all enables.
module pwm_wb_regs
  import pwm_wb_pkg::*;
#(
  parameter logic [31:0] RESET_PERIOD = 32'd1_000_000,
  parameter logic [31:0] RESET_DUTY   = 32'd75_000,
  parameter logic [31:0] BLOCK_ID     = 32'h5057_4D38
) (
  input  logic        clk,
  input  logic        rst,
  pwm_wb_if.slave     bus,
  output logic [31:0] T0, T1, T2, T3, T4, T5, T6, T7,
  output logic [31:0] D0, D1, D2, D3, D4, D5, D6, D7,
  output logic        E0, E1, E2, E3, E4, E5, E6, E7
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  en_stg_q, en_stg_d, en_act_q, en_act_d;
  logic        pend_q, pend_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        acc, wr;
  logic [5:0]  adr_w;
  logic [2:0]  ch_idx;
  logic        is_t, is_d, is_en, commit, kill;
  logic [31:0] rdata;
  logic [NCH-1:0] t_we, d_we;
  logic [31:0] t_stg [NCH];
  logic [31:0] d_stg [NCH];
  logic [31:0] t_act [NCH];
  logic [31:0] d_act [NCH];
  logic [1:0]  unused_adr;

  assign unused_adr = bus.wb_adr_i[1:0];

  // A request is taken only while ack is low, so each access costs two cycles.
  assign acc    = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
  assign wr     = acc & bus.wb_we_i;
  assign adr_w  = bus.wb_adr_i[7:2];
  assign ch_idx = bus.wb_adr_i[4:2];
  assign is_t   = (bus.wb_adr_i[7:5] == ADR_T_BASE[7:5]);
  assign is_d   = (bus.wb_adr_i[7:5] == ADR_D_BASE[7:5]);
  assign is_en  = (adr_w == ADR_EN[7:2]);
  assign commit = wr & (adr_w == ADR_COMMIT[7:2]) & bus.wb_sel_i[0] & bus.wb_dat_i[0];
  assign kill   = wr & (adr_w == ADR_KILL[7:2]) & bus.wb_dat_i[0];

  // Per-channel write strobes.
  always_comb begin
    t_we = '0;
    d_we = '0;
    if (wr && is_t) t_we[ch_idx] = 1'b1;
    if (wr && is_d) d_we[ch_idx] = 1'b1;
  end

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    pwm_wb_chan #(
      .ResetPeriod (RESET_PERIOD),
      .ResetDuty   (RESET_DUTY)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .t_we_i   (t_we[n]),
      .d_we_i   (d_we[n]),
      .sel_i    (bus.wb_sel_i),
      .wdat_i   (bus.wb_dat_i),
      .commit_i (commit),
      .t_stg_o  (t_stg[n]),
      .d_stg_o  (d_stg[n]),
      .t_o      (t_act[n]),
      .d_o      (d_act[n])
    );
  end

  // Read mux: staged values are visible, COMMIT/KILL/unmapped read as zero.
  always_comb begin
    rdata = '0;
    if (is_t) begin
      rdata = t_stg[ch_idx];
    end else if (is_d) begin
      rdata = d_stg[ch_idx];
    end else if (is_en) begin
      rdata = {24'd0, en_stg_q};
    end else if (adr_w == ADR_STATUS[7:2]) begin
      rdata[STATUS_PEND_BIT]                  = pend_q;
      rdata[STATUS_CNT_LSB +: 8]              = cnt_q;
    end else if (adr_w == ADR_ID[7:2]) begin
      rdata = BLOCK_ID;
    end
  end

  // Next-state for handshake, enables, pending flag and commit counter.
  always_comb begin
    ack_d    = acc;
    dat_d    = (acc && !bus.wb_we_i) ? rdata : 32'd0;
    en_stg_d = en_stg_q;
    en_act_d = en_act_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    if (wr && is_en && bus.wb_sel_i[0]) en_stg_d = bus.wb_dat_i[7:0];
    if (wr && (is_t || is_d || is_en))  pend_d   = 1'b1;
    if (commit) begin
      en_act_d = en_stg_q;
      pend_d   = 1'b0;
      cnt_d    = cnt_q + 8'd1;
    end
    // Kill wins over everything touching the enables.
    if (kill) begin
      en_stg_d = '0;
      en_act_d = '0;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_stg_q <= '0;
      en_act_q <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      en_stg_q <= en_stg_d;
      en_act_q <= en_act_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;

  assign T0 = t_act[0];
  assign T1 = t_act[1];
  assign T2 = t_act[2];
  assign T3 = t_act[3];
  assign T4 = t_act[4];
  assign T5 = t_act[5];
  assign T6 = t_act[6];
  assign T7 = t_act[7];
  assign D0 = d_act[0];
  assign D1 = d_act[1];
  assign D2 = d_act[2];
  assign D3 = d_act[3];
  assign D4 = d_act[4];
  assign D5 = d_act[5];
  assign D6 = d_act[6];
  assign D7 = d_act[7];
  assign {E7, E6, E5, E4, E3, E2, E1, E0} = en_act_q;

endmodule

// File: tb/tb_pwm_wb_regs.sv
// Randomised bench for pwm_wb_regs with a scoreboard on bus responses and a
// register-map reference model for the PWM-side outputs.
module tb_pwm_wb_regs;

  localparam logic [31:0] RP  = 32'd1_000_000;
  localparam logic [31:0] RD  = 32'd75_000;
  localparam logic [31:0] BID = 32'h5057_4D38;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_wb_if bus ();

  logic [31:0] t_o [8];
  logic [31:0] d_o [8];
  logic [7:0]  e_o;

  pwm_wb_regs dut (
    .clk (clk), .rst (rst), .bus (bus),
    .T0 (t_o[0]), .T1 (t_o[1]), .T2 (t_o[2]), .T3 (t_o[3]),
    .T4 (t_o[4]), .T5 (t_o[5]), .T6 (t_o[6]), .T7 (t_o[7]),
    .D0 (d_o[0]), .D1 (d_o[1]), .D2 (d_o[2]), .D3 (d_o[3]),
    .D4 (d_o[4]), .D5 (d_o[5]), .D6 (d_o[6]), .D7 (d_o[7]),
    .E0 (e_o[0]), .E1 (e_o[1]), .E2 (e_o[2]), .E3 (e_o[3]),
    .E4 (e_o[4]), .E5 (e_o[5]), .E6 (e_o[6]), .E7 (e_o[7])
  );

  int total = 0;
  int bad   = 0;
  int issued = 0;
  int acks   = 0;

  // Scoreboard entry: bit 32 says whether the data must be checked (reads).
  logic [32:0] exp_q [$];

  // Reference model: the register map as plain arrays.
  logic [31:0] m_st [8];
  logic [31:0] m_sd [8];
  logic [31:0] m_at [8];
  logic [31:0] m_ad [8];
  logic [7:0]  m_se, m_ae, m_cnt;
  bit          m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_st[i] = RP; m_at[i] = RP; m_sd[i] = RD; m_ad[i] = RD;
    end
    m_se = 0; m_ae = 0; m_cnt = 0; m_pend = 0;
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] sel);
    logic [31:0] mask = 0;
    for (int b = 0; b < 4; b++) if (sel[b]) mask |= 32'hFF << (8 * b);
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] model_read(int w);
    if (w < 8)   return m_st[w];
    if (w < 16)  return m_sd[w - 8];
    if (w == 16) return {24'd0, m_se};
    if (w == 18) return {16'd0, m_cnt, 7'd0, m_pend};
    if (w == 19) return BID;
    return 32'd0;
  endfunction

  task automatic model_write(int w, logic [3:0] sel, logic [31:0] dat);
    if (w < 8) begin
      m_st[w] = merge(m_st[w], dat, sel); m_pend = 1;
    end else if (w < 16) begin
      m_sd[w - 8] = merge(m_sd[w - 8], dat, sel); m_pend = 1;
    end else if (w == 16) begin
      if (sel[0]) m_se = dat[7:0];
      m_pend = 1;
    end else if (w == 17 && sel[0] && dat[0]) begin
      m_at = m_st; m_ad = m_sd; m_ae = m_se; m_pend = 0; m_cnt = m_cnt + 8'd1;
    end else if (w == 20 && dat[0]) begin
      m_se = 0; m_ae = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    int errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (t_o[i] !== m_at[i] || d_o[i] !== m_ad[i]) errs++;
    end
    if (e_o !== m_ae) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL outputs@%s: T3=%0d D3=%0d E=0x%02h expected T3=%0d D3=%0d E=0x%02h (%0d diffs)",
               tag, t_o[3], d_o[3], e_o, m_at[3], m_ad[3], m_ae, errs);
    end
  endtask

  // Issue one bus access, queue its expected response, then check the
  // PWM-side outputs during the ack cycle.
  task automatic access(input bit we, input logic [7:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
    int w = int'(adr[7:2]);
    @(negedge clk);
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_sel_i = sel; bus.wb_dat_i = dat;
    exp_q.push_back({~we, (we ? 32'd0 : model_read(w))});
    if (we) model_write(w, sel, dat);
    issued++;
    @(posedge clk);
    @(negedge clk);
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
    check_outputs($sformatf("adr%02h", adr));
  endtask

  // Monitor: pops the scoreboard on every ack; data must be zero otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wb_ack_o) begin
        logic [32:0] e;
        acks++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (e[32]) check("read_data", bus.wb_dat_o, e[31:0]);
        end
      end else if (bus.wb_dat_o !== 32'd0) begin
        check("idle_data", bus.wb_dat_o, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int w;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    bus.wb_adr_i = 0; bus.wb_sel_i = 0; bus.wb_dat_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check("reset_dat", bus.wb_dat_o, 32'd0);
    rst = 0;
    @(negedge clk);
    check_outputs("reset");
    access(0, 8'h48, 4'hF, 0);                       // STATUS = 0
    access(0, 8'h4C, 4'hF, 0);                       // ID

    // Stage channel 3 and enable, outputs must hold until commit.
    access(1, 8'h0C, 4'hF, 32'h0000_4E20);
    access(1, 8'h2C, 4'hF, 32'h0000_1388);
    access(1, 8'h40, 4'h1, 32'h0000_0008);
    access(0, 8'h48, 4'hF, 0);                       // STATUS = 1
    access(1, 8'h44, 4'h1, 32'h1);
    check("T3_commit", t_o[3], 32'd20000);
    check("D3_commit", d_o[3], 32'd5000);
    check("E3_commit", {31'd0, e_o[3]}, 32'd1);
    access(0, 8'h48, 4'hF, 0);                       // STATUS = 0x100
    access(1, 8'h44, 4'h1, 32'h0);                   // commit with bit0=0: no effect

    // Byte-lane write into staged D0.
    access(1, 8'h20, 4'hF, 32'h1234_5678);
    access(1, 8'h20, 4'h1, 32'h0000_00AA);
    access(0, 8'h20, 4'hF, 0);

    // Kill with all channels enabled.
    access(1, 8'h40, 4'h1, 32'hFF);
    access(1, 8'h44, 4'h1, 32'h1);
    check("E_all_on", {24'd0, e_o}, 32'hFF);
    access(1, 8'h50, 4'hF, 32'h1);
    check("E_killed", {24'd0, e_o}, 32'h0);
    access(1, 8'h44, 4'h1, 32'h1);
    check("E_after_kill_commit", {24'd0, e_o}, 32'h0);

    // Counter wrap: 256 commits return it to its current value.
    for (int i = 0; i < 256; i++) access(1, 8'h44, 4'h1, 32'h1);
    access(0, 8'h48, 4'hF, 0);
    access(0, 8'h7C, 4'hF, 0);                       // unmapped read
    access(1, 8'h7C, 4'hF, 32'hDEAD_BEEF);           // unmapped write ignored

    // Randomised mix over the whole map plus some unmapped words.
    for (int i = 0; i < 300; i++) begin
      w = $urandom_range(0, 23);
      if (w == 23) w = 31;
      adr = {w[5:0], 2'($urandom)};
      sel = 4'($urandom);
      if (w < 16) begin
        if (sel == 0) sel = 4'hF;
      end else begin
        sel[0] = 1'b1;
      end
      dat = $urandom;
      if (w == 20) dat[0] = ($urandom_range(0, 7) == 0);
      if (w == 17) dat[0] = ($urandom_range(0, 2) != 0);
      access(1'($urandom), adr, sel, dat);
    end

    // Reset during an access that is being acknowledged.
    access(1, 8'h14, 4'hF, 32'd1234);
    access(1, 8'h44, 4'h1, 32'h1);
    @(negedge clk);
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
    bus.wb_adr_i = 8'h54; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h1;
    @(posedge clk);
    #1;
    rst = 1;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
    model_reset();
    #1;
    check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check_outputs("mid_reset");
    @(negedge clk);
    rst = 0;
    access(0, 8'h14, 4'hF, 0);
    access(0, 8'h48, 4'hF, 0);

    repeat (3) @(negedge clk);
    check("ack_count", acks, issued);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
